// File: rtl/fp_resp_parser.sv
// fp_resp_parser
// Collects one R305 fingerprint-sensor response frame after each arm pulse
// and reduces it to a result code, a matched template ID and a match score.
//
// Expected frame (16 bytes):
//   EF 01 | addr[31:24] addr[23:16] addr[15:8] addr[7:0] | 07 | 00 07 |
//   confirm page_hi page_lo score_hi score_lo | csum_hi csum_lo
//
// Ports
//   clk1      in   single rising-edge clock
//   reset     in   asynchronous active-high reset
//   arm       in   one-cycle pulse, starts collection of one frame (ignored while busy)
//   rx_byte   in   [7:0] received UART byte
//   rx_ready  in   one-cycle strobe qualifying rx_byte
//   busy      out  high while a frame is being collected
//   done      out  one-cycle pulse, result outputs valid
//   status    out  [2:0] 0 OK, 1 NOMATCH, 2 SENSOR, 3 CSUM, 4 FRAME, 5 TIMEOUT, 6 RANGE
//   voter_id  out  [7:0] low byte of matched template page (updated only on OK)
//   score     out  [15:0] match score (updated only on OK)

module fp_resp_parser #(
  parameter logic [31:0] DEV_ADDR    = 32'hFFFF_FFFF,
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
) (
  input  logic        clk1,
  input  logic        reset,
  input  logic        arm,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic [2:0]  status,
  output logic [7:0]  voter_id,
  output logic [15:0] score
);

  typedef enum logic [2:0] {
    IDLE, HDR0, HDR1, ADDR, PID, LEN, BODY, CSUM
  } state_t;

  localparam logic [2:0] ST_OK      = 3'd0;
  localparam logic [2:0] ST_NOMATCH = 3'd1;
  localparam logic [2:0] ST_SENSOR  = 3'd2;
  localparam logic [2:0] ST_CSUM    = 3'd3;
  localparam logic [2:0] ST_FRAME   = 3'd4;
  localparam logic [2:0] ST_TIMEOUT = 3'd5;
  localparam logic [2:0] ST_RANGE   = 3'd6;

  state_t      state;
  logic [2:0]  idx;         // byte position within ADDR/LEN/BODY/CSUM
  logic [23:0] tmr;         // cycles since arm or the last received byte
  logic [15:0] csum_acc;    // running sum of PID, LEN and body bytes
  logic        frame_err;   // sticky: bad address, PID or LEN seen
  logic [7:0]  confirm;
  logic [7:0]  page_hi;
  logic [7:0]  page_lo;
  logic [7:0]  score_hi;
  logic [7:0]  score_lo;
  logic [7:0]  csum_hi;

  logic [7:0]  exp_addr;
  logic [15:0] rx_csum;
  logic [2:0]  final_status;

  // Address byte expected at the current position, MSB first.
  always_comb begin
    exp_addr = DEV_ADDR[7:0];
    case (idx[1:0])
      2'd0:    exp_addr = DEV_ADDR[31:24];
      2'd1:    exp_addr = DEV_ADDR[23:16];
      2'd2:    exp_addr = DEV_ADDR[15:8];
      default: exp_addr = DEV_ADDR[7:0];
    endcase
  end

  // Result code for the frame, evaluated while the last checksum byte is on
  // rx_byte. Structural errors outrank checksum errors, which outrank the
  // sensor's own confirmation code.
  assign rx_csum = {csum_hi, rx_byte};

  always_comb begin
    final_status = ST_OK;
    if (frame_err)
      final_status = ST_FRAME;
    else if (rx_csum != csum_acc)
      final_status = ST_CSUM;
    else if (confirm == 8'h09)
      final_status = ST_NOMATCH;
    else if (confirm != 8'h00)
      final_status = ST_SENSOR;
    else if (page_hi != 8'h00)
      final_status = ST_RANGE;
  end

  // Frame collection FSM. A received byte always wins over the timeout in
  // the same cycle, so a byte arriving exactly at the deadline still counts.
  always_ff @(posedge clk1 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= 3'd0;
      tmr       <= 24'd0;
      csum_acc  <= 16'd0;
      frame_err <= 1'b0;
      confirm   <= 8'h00;
      page_hi   <= 8'h00;
      page_lo   <= 8'h00;
      score_hi  <= 8'h00;
      score_lo  <= 8'h00;
      csum_hi   <= 8'h00;
      busy      <= 1'b0;
      done      <= 1'b0;
      status    <= ST_OK;
      voter_id  <= 8'h00;
      score     <= 16'h0000;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state     <= HDR0;
            busy      <= 1'b1;
            idx       <= 3'd0;
            tmr       <= 24'd0;
            csum_acc  <= 16'd0;
            frame_err <= 1'b0;
          end
        end

        default: begin
          if (rx_ready) begin
            tmr <= 24'd0;
            case (state)
              HDR0: begin
                if (rx_byte == 8'hEF)
                  state <= HDR1;
              end

              // A repeated EF may itself be the real start of header.
              HDR1: begin
                if (rx_byte == 8'h01) begin
                  state <= ADDR;
                  idx   <= 3'd0;
                end else if (rx_byte != 8'hEF) begin
                  state <= HDR0;
                end
              end

              ADDR: begin
                if (rx_byte != exp_addr)
                  frame_err <= 1'b1;
                if (idx == 3'd3) begin
                  state <= PID;
                  idx   <= 3'd0;
                end else begin
                  idx <= idx + 3'd1;
                end
              end

              PID: begin
                if (rx_byte != 8'h07)
                  frame_err <= 1'b1;
                csum_acc <= csum_acc + {8'h00, rx_byte};
                state    <= LEN;
                idx      <= 3'd0;
              end

              LEN: begin
                if ((idx == 3'd0 && rx_byte != 8'h00) ||
                    (idx != 3'd0 && rx_byte != 8'h07))
                  frame_err <= 1'b1;
                csum_acc <= csum_acc + {8'h00, rx_byte};
                if (idx != 3'd0) begin
                  state <= BODY;
                  idx   <= 3'd0;
                end else begin
                  idx <= 3'd1;
                end
              end

              BODY: begin
                csum_acc <= csum_acc + {8'h00, rx_byte};
                case (idx)
                  3'd0:    confirm  <= rx_byte;
                  3'd1:    page_hi  <= rx_byte;
                  3'd2:    page_lo  <= rx_byte;
                  3'd3:    score_hi <= rx_byte;
                  default: score_lo <= rx_byte;
                endcase
                if (idx == 3'd4) begin
                  state <= CSUM;
                  idx   <= 3'd0;
                end else begin
                  idx <= idx + 3'd1;
                end
              end

              CSUM: begin
                if (idx == 3'd0) begin
                  csum_hi <= rx_byte;
                  idx     <= 3'd1;
                end else begin
                  state  <= IDLE;
                  busy   <= 1'b0;
                  done   <= 1'b1;
                  status <= final_status;
                  if (final_status == ST_OK) begin
                    voter_id <= page_lo;
                    score    <= {score_hi, score_lo};
                  end
                end
              end

              default: begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            endcase
          end else if (tmr == TIMEOUT_CYC - 24'd1) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b1;
            status <= ST_TIMEOUT;
          end else begin
            tmr <= tmr + 24'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_resp_parser.sv
// tb_fp_resp_parser
// Directed self-checking bench for fp_resp_parser, built with a 16-cycle
// inter-byte timeout so the timeout path can be exercised quickly.
// Drives inputs on the falling edge and samples outputs away from the
// rising edge; counts done pulses independently of the frame tasks.

module tb_fp_resp_parser;

  logic        clk1 = 1'b0;
  logic        reset = 1'b0;
  logic        arm = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready = 1'b0;
  logic        busy;
  logic        done;
  logic [2:0]  status;
  logic [7:0]  voter_id;
  logic [15:0] score;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_acc = 0;

  fp_resp_parser #(
    .DEV_ADDR   (32'hFFFF_FFFF),
    .TIMEOUT_CYC(24'd16)
  ) dut (
    .clk1    (clk1),
    .reset   (reset),
    .arm     (arm),
    .rx_byte (rx_byte),
    .rx_ready(rx_ready),
    .busy    (busy),
    .done    (done),
    .status  (status),
    .voter_id(voter_id),
    .score   (score)
  );

  always #5 clk1 = ~clk1;

  always @(posedge clk1) cyc <= cyc + 1;

  // Done is a one-cycle pulse, so each pulse is seen on exactly one falling edge.
  always @(negedge clk1) begin
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
  end

  // Hand-built frames, first byte in the top bits.
  localparam logic [127:0] F_OK      = 128'hEF01_FFFF_FFFF_0700_0700_0005_0064_0077;
  localparam logic [127:0] F_NOMATCH = 128'hEF01_FFFF_FFFF_0700_0709_0000_0000_0017;
  localparam logic [127:0] F_BADSUM  = 128'hEF01_FFFF_FFFF_0700_0700_0005_0064_0078;
  localparam logic [127:0] F_WIDE    = 128'hEF01_FFFF_FFFF_0700_0700_000A_FFFF_0216;
  localparam logic [127:0] F_PID     = 128'hEF01_FFFF_FFFF_0100_0700_0005_0064_0071;
  localparam logic [127:0] F_SENSOR  = 128'hEF01_FFFF_FFFF_0700_0702_0000_0000_0010;
  localparam logic [127:0] F_RANGE   = 128'hEF01_FFFF_FFFF_0700_0700_0105_0064_0078;
  localparam logic [127:0] F_ADDR    = 128'hEF01_FFFF_FEFF_0700_0700_0005_0064_0077;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Sends one byte after 'gap' idle cycles; starts and ends on a falling edge.
  task automatic applyStimulus(input logic [7:0] b, input int gap);
    repeat (gap) @(negedge clk1);
    rx_byte  = b;
    rx_ready = 1'b1;
    @(negedge clk1);
    rx_ready = 1'b0;
    last_acc = cyc;
  endtask

  task automatic armDut();
    @(negedge clk1);
    arm = 1'b1;
    @(negedge clk1);
    arm = 1'b0;
  endtask

  task automatic sendFrame(input string name, input logic [127:0] f, input int gap,
                           input int start);
    logic [127:0] fr;
    fr = f;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(fr[127 - 8*i -: 8], gap);
      if (i == 14) begin
        #1;
        checkOutput({name, " early_done"}, done_cnt - start, 0);
      end
    end
  endtask

  task automatic checkResult(input string name, input int start, input logic [2:0] st,
                             input logic [7:0] vid, input logic [15:0] sc);
    repeat (3) @(negedge clk1);
    #1;
    checkOutput({name, " done_pulses"}, done_cnt - start, 1);
    checkOutput({name, " status"}, status, st);
    checkOutput({name, " voter_id"}, voter_id, vid);
    checkOutput({name, " score"}, score, sc);
    checkOutput({name, " busy"}, busy, 0);
  endtask

  task automatic runFrame(input string name, input logic [127:0] f, input int gap,
                          input logic [2:0] st, input logic [7:0] vid,
                          input logic [15:0] sc);
    int start;
    armDut();
    start = done_cnt;
    sendFrame(name, f, gap, start);
    checkResult(name, start, st, vid, sc);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    logic [127:0] fr;

    // Reset state, applied asynchronously.
    reset = 1'b1;
    #1;
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset status", status, 0);
    checkOutput("reset voter_id", voter_id, 0);
    checkOutput("reset score", score, 0);
    repeat (3) @(negedge clk1);
    reset = 1'b0;

    // Bytes in IDLE are ignored.
    applyStimulus(8'hEF, 1);
    applyStimulus(8'h01, 0);
    #1;
    checkOutput("idle busy", busy, 0);
    checkOutput("idle done", done_cnt, 0);

    // Busy rises the cycle after arm.
    armDut();
    #1;
    checkOutput("arm busy", busy, 1);
    start = done_cnt;
    sendFrame("ok", F_OK, 1, start);
    checkResult("ok", start, 3'd0, 8'h05, 16'h0064);

    runFrame("nomatch", F_NOMATCH, 1, 3'd1, 8'h05, 16'h0064);
    runFrame("badsum",  F_BADSUM,  1, 3'd3, 8'h05, 16'h0064);
    runFrame("wide",    F_WIDE,    0, 3'd0, 8'h0A, 16'hFFFF);

    // Junk and doubled EF ahead of the real header.
    armDut();
    start = done_cnt;
    applyStimulus(8'h33, 1);
    applyStimulus(8'hEF, 1);
    applyStimulus(8'hEF, 1);
    sendFrame("resync", F_OK, 1, start);
    checkResult("resync", start, 3'd0, 8'h05, 16'h0064);

    runFrame("pid",    F_PID,    1, 3'd4, 8'h05, 16'h0064);
    runFrame("sensor", F_SENSOR, 2, 3'd2, 8'h05, 16'h0064);
    runFrame("range",  F_RANGE,  1, 3'd6, 8'h05, 16'h0064);
    runFrame("addr",   F_ADDR,   1, 3'd4, 8'h05, 16'h0064);

    // Every byte lands in the timeout cycle itself and must still be accepted.
    runFrame("gap15", F_WIDE, 15, 3'd0, 8'h0A, 16'hFFFF);

    // Timeout: header only, then silence.
    armDut();
    start = done_cnt;
    applyStimulus(8'hEF, 1);
    applyStimulus(8'h01, 1);
    for (int i = 0; i < 40 && done_cnt == start; i++) @(negedge clk1);
    #1;
    checkOutput("timeout done_pulses", done_cnt - start, 1);
    checkOutput("timeout latency", done_cyc - last_acc, 16);
    checkOutput("timeout status", status, 3'd5);
    checkOutput("timeout voter_id", voter_id, 8'h0A);
    checkOutput("timeout busy", busy, 0);

    // Reset after eight bytes of a frame drops it without a done pulse.
    armDut();
    start = done_cnt;
    fr = F_OK;
    for (int i = 0; i < 8; i++) applyStimulus(fr[127 - 8*i -: 8], 1);
    reset = 1'b1;
    #1;
    checkOutput("midreset busy", busy, 0);
    repeat (2) @(negedge clk1);
    reset = 1'b0;
    repeat (20) @(negedge clk1);
    #1;
    checkOutput("midreset done_pulses", done_cnt - start, 0);
    checkOutput("midreset voter_id", voter_id, 0);
    checkOutput("midreset score", score, 0);
    runFrame("postreset", F_OK, 1, 3'd0, 8'h05, 16'h0064);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
